// File: rtl/ti_gf24_inv_pipe.sv
// Two-share threshold-implementation GF(2^4) inverter, three register stages.
// Input and output nibbles are in the Canright normal-basis tower, with the
// high pair [3:2] and the low pair [1:0]. Every nonlinear layer is followed
// by a register, and the domain-crossing products are refreshed with rnd.
//
// Handshake: a transfer happens on a port when valid and ready are both high
// on a rising CLK edge. The pipeline advances as a whole (adv) whenever the
// last stage is empty or is being drained. Bubbles travel with the data and
// are never collapsed. While adv is low, every register holds.
module ti_gf24_inv_pipe (
    input  logic       CLK,
    input  logic       RST,
    input  logic       in_valid,
    output logic       in_ready,
    input  logic [3:0] in_x0,
    input  logic [3:0] in_x1,
    input  logic [5:0] rnd,
    output logic       out_valid,
    input  logic       out_ready,
    output logic [3:0] out_y0,
    output logic [3:0] out_y1,
    output logic       busy
);

    // GF(2^2) multiply in the normal basis; unity is 2'b11.
    function automatic logic [1:0] gf4_mul(input logic [1:0] a, input logic [1:0] b);
        logic e;
        e = (a[1] ^ a[0]) & (b[1] ^ b[0]);
        return {(a[1] & b[1]) ^ e, (a[0] & b[0]) ^ e};
    endfunction

    // N * a^2. This is linear, so each share is handled on its own.
    function automatic logic [1:0] gf4_sqsc(input logic [1:0] a);
        return {a[1], a[1] ^ a[0]};
    endfunction

    // In a normal basis, squaring is a bit swap.
    function automatic logic [1:0] gf4_sq(input logic [1:0] a);
        return {a[0], a[1]};
    endfunction

    logic v1, v2, v3;
    logic adv, accept;

    assign adv       = ~v3 | out_ready;
    assign in_ready  = adv;
    assign accept    = in_valid & adv;
    assign out_valid = v3;
    assign busy      = v1 | v2 | v3;

    // Input share fields
    logic [1:0] h0, l0, h1, l1, r1;
    assign h0 = in_x0[3:2];
    assign l0 = in_x0[1:0];
    assign h1 = in_x1[3:2];
    assign l1 = in_x1[1:0];
    assign r1 = rnd[1:0];

    // Stage 1 registers
    logic [1:0] s1_t00, s1_t01, s1_t10, s1_t11;
    logic [1:0] s1_h0, s1_l0, s1_h1, s1_l1;
    logic [3:0] s1_r2;

    // Stage 2 cross terms
    logic [1:0] yh00, yh01, yh10, yh11;
    logic [1:0] yl00, yl01, yl10, yl11;

    // Stage 2 combinational: recombine d per domain, then square to get e
    logic [1:0] d0, d1, e0, e1;
    assign d0 = s1_t00 ^ s1_t01;
    assign d1 = s1_t10 ^ s1_t11;
    assign e0 = gf4_sq(d0);
    assign e1 = gf4_sq(d1);

    // Valid chain: shifts on every advance, so bubbles are kept in place.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            v1 <= 1'b0;
            v2 <= 1'b0;
            v3 <= 1'b0;
        end else if (adv) begin
            v1 <= accept;
            v2 <= v1;
            v3 <= v2;
        end
    end

    // Stage 1: first nonlinear layer. The cross products are masked with r1.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            s1_t00 <= 2'b00;
            s1_t01 <= 2'b00;
            s1_t10 <= 2'b00;
            s1_t11 <= 2'b00;
            s1_h0  <= 2'b00;
            s1_l0  <= 2'b00;
            s1_h1  <= 2'b00;
            s1_l1  <= 2'b00;
            s1_r2  <= 4'h0;
        end else if (accept) begin
            s1_t00 <= gf4_mul(h0, l0) ^ gf4_sqsc(h0 ^ l0);
            s1_t01 <= gf4_mul(h0, l1) ^ r1;
            s1_t10 <= gf4_mul(h1, l0) ^ r1;
            s1_t11 <= gf4_mul(h1, l1) ^ gf4_sqsc(h1 ^ l1);
            s1_h0  <= h0;
            s1_l0  <= l0;
            s1_h1  <= h1;
            s1_l1  <= l1;
            s1_r2  <= rnd[5:2];
        end
    end

    // Stage 2: second nonlinear layer. Cross-domain terms are masked with r2.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            yh00 <= 2'b00;
            yh01 <= 2'b00;
            yh10 <= 2'b00;
            yh11 <= 2'b00;
            yl00 <= 2'b00;
            yl01 <= 2'b00;
            yl10 <= 2'b00;
            yl11 <= 2'b00;
        end else if (adv && v1) begin
            yh00 <= gf4_mul(e0, s1_l0);
            yh01 <= gf4_mul(e0, s1_l1) ^ s1_r2[1:0];
            yh10 <= gf4_mul(e1, s1_l0) ^ s1_r2[1:0];
            yh11 <= gf4_mul(e1, s1_l1);
            yl00 <= gf4_mul(e0, s1_h0);
            yl01 <= gf4_mul(e0, s1_h1) ^ s1_r2[3:2];
            yl10 <= gf4_mul(e1, s1_h0) ^ s1_r2[3:2];
            yl11 <= gf4_mul(e1, s1_h1);
        end
    end

    // Stage 3: compress the cross terms into one output share per domain.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            out_y0 <= 4'h0;
            out_y1 <= 4'h0;
        end else if (adv && v2) begin
            out_y0 <= {yh00 ^ yh01, yl00 ^ yl01};
            out_y1 <= {yh10 ^ yh11, yl10 ^ yl11};
        end
    end

endmodule

// File: doc/ti_gf24_inv_pipe.md
Name: ti_gf24_inv_pipe

Overview:
- 2-share threshold-implementation GF(2^4) inverter, 3 pipeline stages, feeding the masked GF(2^2) scaling/multiplication stage of the masked S-box datapath.
- Takes a 2-share nibble in Canright normal-basis tower representation and produces 2 shares of its inverse.
- Uses domain-oriented cross products, a register after every nonlinear layer, and fresh randomness.
- Valid/ready handshake with global stall.

Parameters:
- none (field, basis and share count fixed)

Ports:
- CLK  input  1  clock, rising edge
- RST  input  1  reset, asynchronous, active-high
- in_valid  input  1  input nibble shares valid
- in_ready  output  1  block can accept this cycle
- in_x0  input  4  share 0 of x; [3:2]=h, [1:0]=l
- in_x1  input  4  share 1 of x
- rnd  input  6  fresh randomness; [1:0]=r1, [5:2]=r2; sampled on acceptance
- out_valid  output  1  output shares valid
- out_ready  input  1  downstream accepts
- out_y0  output  4  share 0 of x^-1
- out_y1  output  4  share 1 of x^-1
- busy  output  1  any pipeline stage valid

Behaviour:
- Reset is asynchronous and active-high on RST; clock is CLK.
- While RST is high, all stage valids, all data registers, out_y0, out_y1, out_valid and busy are 0.

GF(2^2) arithmetic (bits [1],[0]):
- Multiply: e=(a1^a0)&(b1^b0); c={a1&b1^e, a0&b0^e}.
- Square: swap bits.
- sqsc(a) = N*a^2 = {a1, a1^a0}. Linear, so it is applied per share.

Inversion function (unmasked):
- d = sqsc(h^l) ^ h*l.
- e = d^2.
- y = {e*l, e*h}.
- Unity is 4'hF, 0 maps to 0.

Handshake:
- adv = ~v3 | out_ready.
- in_ready = adv.
- Accept when in_valid & adv.
- On adv, every stage shifts by one: v1<=accept, v2<=v1, v3<=v2, and data moves with them.
- When adv=0, all registers hold, including data behind bubbles.
- Bubbles are not collapsed.
- out_valid=v3. out_y0/out_y1 stay stable while out_valid & ~out_ready.
- busy = v1|v2|v3.

Stage 1 (registered on accept):
- t00 = h0*l0 ^ sqsc(h0^l0)
- t01 = h0*l1 ^ r1
- t10 = h1*l0 ^ r1
- t11 = h1*l1 ^ sqsc(h1^l1)
- Also registers h0,l0,h1,l1 and r2.

Stage 2:
- d0 = t00^t01, d1 = t10^t11, e_i = swap(d_i).
- Register the eight cross terms:
  - yh: e_i*l_j for (i,j) in {00,01,10,11}; r2[1:0] added to terms 01 and 10.
  - yl: e_i*h_j likewise, with r2[3:2].
- Share domain i is never combined with domain j≠i before a register, except through the masked terms.

Stage 3:
- out_y0 = {yh00^yh01, yl00^yl01}
- out_y1 = {yh10^yh11, yl10^yl11}
- Register both.

Timing and boundary cases:
- Latency is 3 cycles from acceptance to out_valid, with no stall.
- Throughput is 1 nibble per cycle.
- Stall while full: all 3 stages hold and in_ready=0.
- Simultaneous out_ready and in_valid when full: output is retired and new input accepted in the same cycle.
- RST asserted mid-operation: all in-flight data is discarded immediately; nothing is emitted after release.
- Invariant: out_y0^out_y1 is independent of rnd. For 0 input the result is 0.

Test Plan:
- Reset: assert RST mid-stream with 2 items in flight -> out_valid=0, busy=0, out_y0=out_y1=0 immediately; no output after release.
- Unity/zero: x0=4'hA, x1=4'h5 (x=F), rnd=6'h2D -> after 3 cycles out_y0^out_y1=4'hF. x0=x1=4'h7 (x=0) -> result 4'h0.
- Exhaustive: all 16 x × 16 random share splits × random rnd, out_ready=1 -> a 1/cycle stream; each out_y0^out_y1 equals the model inverse; x*y=4'hF for every nonzero x; order preserved.
- Backpressure: stream 5 items, out_ready=0 for 4 cycles starting when v3=1 -> in_ready=0 once full, outputs held stable, no loss or duplication, all 5 correct.
- Bubbles: in_valid toggled 1,0,1,0 -> out_valid pattern 1,0,1,0 starting 3 cycles later, busy tracks occupancy.
- Randomness: same x=4'h3 with rnd=0 and rnd=6'h3F -> individual output shares differ, XOR identical.
